// File: rtl/led_writer.sv
// Memory-mapped LED output peripheral: DATA/MASK/PERIOD registers, blink prescaler, 1-cycle readback.
// Optional macro LED_SETCLR_EN adds set/clear/toggle aliases of DATA at addresses 4..6.
module led_writer #(
    parameter int LED_W    = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         writeData,
    input  logic                writeEnable,
    input  logic                readEnable,
    input  logic [29:0]         memAddress,
    output logic [LED_W-1:0]    leds,
    output logic [31:0]         readData
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
`ifdef LED_SETCLR_EN
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_TGL    = 3'd6;
`endif

    logic [LED_W-1:0]    data_q, data_d;
    logic [LED_W-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] counter_q, counter_d;
    logic                phase_q, phase_d;
    logic [31:0]         read_data_q, read_data_d;

    logic [2:0]          addr;
    logic [LED_W-1:0]    wd;
    logic                period_wr;
    logic [31:0]         status_word;
    logic [31:0]         rd_val;

    // Only the low address bits and low data bits are meaningful.
    logic unused_bits;
    assign unused_bits = &{1'b0, memAddress[29:3], writeData};

    assign addr      = memAddress[2:0];
    assign wd        = writeData[LED_W-1:0];
    assign period_wr = writeEnable && (addr == ADDR_PERIOD);

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (writeEnable) begin
            case (addr)
                ADDR_DATA:   data_d   = wd;
                ADDR_MASK:   mask_d   = wd;
                ADDR_PERIOD: period_d = writeData[PERIOD_W-1:0];
`ifdef LED_SETCLR_EN
                ADDR_SET:    data_d   = data_q | wd;
                ADDR_CLR:    data_d   = data_q & ~wd;
                ADDR_TGL:    data_d   = data_q ^ wd;
`endif
                default:     ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle so a shrunken period never waits out a long wrap.
    always_comb begin
        counter_d = counter_q;
        phase_d   = phase_q;
        if (period_wr || (period_q == '0)) begin
            counter_d = '0;
            phase_d   = 1'b0;
        end else if (counter_q == period_q) begin
            counter_d = '0;
            phase_d   = ~phase_q;
        end else begin
            counter_d = counter_q + 1'b1;
        end
    end

    always_comb begin
        status_word             = '0;
        status_word[0]          = phase_q;
        status_word[PERIOD_W:1] = counter_q;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_DATA:   rd_val[LED_W-1:0]    = data_q;
            ADDR_MASK:   rd_val[LED_W-1:0]    = mask_q;
            ADDR_PERIOD: rd_val[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: rd_val               = status_word;
`ifdef LED_SETCLR_EN
            ADDR_SET, ADDR_CLR, ADDR_TGL: rd_val[LED_W-1:0] = data_q;
`endif
            default:     rd_val = '0;
        endcase
        read_data_d = readEnable ? rd_val : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= '0;
            mask_q      <= '0;
            period_q    <= '0;
            counter_q   <= '0;
            phase_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            data_q      <= data_d;
            mask_q      <= mask_d;
            period_q    <= period_d;
            counter_q   <= counter_d;
            phase_q     <= phase_d;
            read_data_q <= read_data_d;
        end
    end

    assign leds     = data_q ^ (mask_q & {LED_W{phase_q}});
    assign readData = read_data_q;

endmodule

// File: tb/tb_led_writer.sv
// Directed bench for led_writer: read results flow through a scoreboard queue, leds checked after each edge.
module tb_led_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] writeData;
    logic        writeEnable;
    logic        readEnable;
    logic [29:0] memAddress;
    logic [15:0] leds;
    logic [31:0] readData;

    int passed = 0;
    int total  = 0;
    logic [31:0] sb_q[$];

    led_writer #(.LED_W(16), .PERIOD_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readEnable  (readEnable),
        .memAddress  (memAddress),
        .leds        (leds),
        .readData    (readData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        memAddress  = {27'd0, a};
        writeData   = d;
        writeEnable = 1'b1;
        tick();
        writeEnable = 1'b0;
        $display("write addr %0d data %h -> leds %h", a, d, leds);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] e;
        sb_q.push_back(exp);
        memAddress = {27'd0, a};
        readEnable = 1'b1;
        tick();
        readEnable = 1'b0;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        $display("read  addr %0d -> %h", a, readData);
        check("read", readData, e);
    endtask

    initial begin
        logic [15:0] exp_leds;
        rst = 1'b0; writeEnable = 1'b0; readEnable = 1'b0; writeData = '0; memAddress = '0;

        // reset held with random bus traffic
        for (int i = 0; i < 5; i++) begin
            writeEnable = 1'($urandom_range(0, 1));
            readEnable  = 1'($urandom_range(0, 1));
            writeData   = $urandom;
            memAddress  = 30'($urandom);
            tick();
            check("rst_leds", {16'd0, leds}, 32'd0);
            check("rst_rdata", readData, 32'd0);
        end
        writeEnable = 1'b0; readEnable = 1'b0;
        rst = 1'b1;
        for (int a = 0; a < 4; a++) bus_read(3'(a), 32'd0);

        // data write, truncation, readback and read-strobe drop
        bus_write(3'd0, 32'h1234_A5A5);
        check("data_leds", {16'd0, leds}, 32'h0000_A5A5);
        bus_read(3'd0, 32'h0000_A5A5);
        tick();
        check("rdata_idle", readData, 32'd0);

        // blink: half-period of 4 cycles, upper PERIOD bits discarded
        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd1, 32'hFFFF_0F0F);
        bus_write(3'd2, 32'hFF00_0003);
        check("blink_start", {16'd0, leds}, 32'h0000_00FF);
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_leds = (((i / 4) % 2) == 1) ? 16'h0FF0 : 16'h00FF;
            check("blink", {16'd0, leds}, {16'd0, exp_leds});
        end
        bus_read(3'd1, 32'h0000_0F0F);
        bus_read(3'd2, 32'h0000_0003);
        bus_write(3'd2, 32'd0);
        check("blink_off", {16'd0, leds}, 32'h0000_00FF);
        tick(); tick();
        check("blink_hold", {16'd0, leds}, 32'h0000_00FF);
        bus_read(3'd3, 32'd0);

        // period rewrite mid-count
        bus_write(3'd2, 32'd10);
        repeat (6) tick();
        bus_read(3'd3, 32'd6 << 1);
        bus_write(3'd2, 32'd2);
        check("rewrite_clr", {16'd0, leds}, 32'h0000_00FF);
        tick(); tick();
        check("rewrite_pre", {16'd0, leds}, 32'h0000_00FF);
        tick();
        check("rewrite_tgl", {16'd0, leds}, 32'h0000_0FF0);
        bus_read(3'd3, 32'd1);

        // same-address read+write, and STATUS write ignored
        bus_write(3'd2, 32'd0);
        bus_write(3'd0, 32'h0000_0001);
        sb_q.push_back(32'h0000_0001);
        memAddress = 30'd0; writeData = 32'h0000_0002;
        writeEnable = 1'b1; readEnable = 1'b1;
        tick();
        writeEnable = 1'b0; readEnable = 1'b0;
        $display("rw    addr 0 data 00000002 -> %h", readData);
        check("rw_read", readData, sb_q.pop_front());
        check("rw_leds", {16'd0, leds}, 32'h0000_0002);
        bus_write(3'd3, 32'hFFFF_FFFF);
        check("status_wr_leds", {16'd0, leds}, 32'h0000_0002);
        bus_read(3'd3, 32'd0);
        bus_read(3'd0, 32'h0000_0002);

        // set/clear/toggle aliases
        bus_write(3'd0, 32'h0000_00F0);
`ifdef LED_SETCLR_EN
        bus_write(3'd4, 32'h0000_000F);
        check("set", {16'd0, leds}, 32'h0000_00FF);
        bus_write(3'd5, 32'h0000_0030);
        check("clr", {16'd0, leds}, 32'h0000_00CF);
        bus_write(3'd6, 32'h0000_FFFF);
        check("tgl", {16'd0, leds}, 32'h0000_FF30);
        bus_read(3'd4, 32'h0000_FF30);
`else
        bus_write(3'd4, 32'h0000_000F);
        check("set", {16'd0, leds}, 32'h0000_00F0);
        bus_write(3'd5, 32'h0000_0030);
        check("clr", {16'd0, leds}, 32'h0000_00F0);
        bus_write(3'd6, 32'h0000_FFFF);
        check("tgl", {16'd0, leds}, 32'h0000_00F0);
        bus_read(3'd4, 32'd0);
`endif
        bus_write(3'd7, 32'h0000_FFFF);
        bus_read(3'd7, 32'd0);

        // asynchronous reset mid-blink and mid-read
        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd2, 32'd1);
        tick(); tick();
        check("pre_rst_leds", {16'd0, leds}, 32'h0000_0FF0);
        bus_read(3'd0, 32'h0000_00FF);
        #2 rst = 1'b0;
        #1;
        check("async_leds", {16'd0, leds}, 32'd0);
        check("async_rdata", readData, 32'd0);
        #2 rst = 1'b1;
        tick();
        check("post_rst_leds", {16'd0, leds}, 32'd0);
        for (int a = 0; a < 4; a++) bus_read(3'(a), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_writer.md
Name: led_writer

Overview:
- Memory-mapped output peripheral that drives the board LEDs from CPU stores. It is the write-side counterpart of the switch-reading input peripheral.
- Sits on the same data-memory bus: writeData/writeEnable/readEnable/memAddress. An external decoder asserts the enables only when this peripheral is selected.
- Holds an LED data register and a blink mask. A programmable prescaler drives a blink phase that toggles the masked LEDs.
- All registers read back with a fixed one-cycle latency.

Parameters:
- LED_W, 16, number of LED outputs; also the width of the data and mask registers.
- PERIOD_W, 24, width of the blink period register and its prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low. rst=0 clears all state immediately.
- writeData  input  32  store data from the CPU.
- writeEnable  input  1  store strobe, sampled at the clk rising edge.
- readEnable  input  1  load strobe, sampled at the clk rising edge.
- memAddress  input  30  word address. Only bits [2:0] are decoded; bits [29:3] are ignored.
- leds  output  LED_W  LED drive.
- readData  output  32  registered load data.

Behaviour:
- Register map, by memAddress[2:0]:
  - 0 DATA: LED_W bits, R/W.
  - 1 MASK: LED_W bits, R/W.
  - 2 PERIOD: PERIOD_W bits, R/W.
  - 3 STATUS: RO; bit0 = phase, bits [PERIOD_W:1] = current counter value.
  - 4..7: see Optional Feature.
- Writes:
  - On a rising edge with writeEnable=1, the addressed register loads writeData, truncated to the register width. Upper bits are discarded.
  - Writes to STATUS are ignored.
- Reads:
  - On a rising edge with readEnable=1, readData <= zero-extended contents of the addressed register.
  - When readEnable=0, readData <= 0.
  - Latency is exactly one cycle. readData is valid the cycle after the strobe.
- Simultaneous readEnable and writeEnable to the same address: readData returns the pre-write value; the write still takes effect.
- Blink prescaler (counter PERIOD_W bits, phase 1 bit):
  - PERIOD=0: counter and phase are held at 0, so blinking is disabled.
  - PERIOD=P>0: counter increments each cycle. At counter==P it wraps to 0 and phase toggles. One phase half-period is therefore P+1 cycles.
  - Writing PERIOD clears counter and phase on the same edge. The new P applies from the next cycle.
  - Writing PERIOD to a value below the current counter takes effect via that clear, so no long wrap can occur.
- Output: leds = DATA ^ (MASK & {LED_W{phase}}). This is combinational from registers only, so it is glitch-free. A DATA/MASK write is visible on leds immediately after the write edge.
- Reset (rst=0, asynchronous): DATA=0, MASK=0, PERIOD=0, counter=0, phase=0, readData=0, hence leds=0. Asserting reset mid-blink or mid-read aborts at once. The first edge after release behaves as a normal cycle.

Optional Feature:
- Macro: LED_SETCLR_EN.
- Defined: atomic bit-operation aliases of DATA.
  - Writes to address 4 perform DATA |= wd.
  - Writes to address 5 perform DATA &= ~wd.
  - Writes to address 6 perform DATA ^= wd.
  - wd = writeData[LED_W-1:0].
  - Reads of addresses 4..6 return DATA. Address 7 is reserved: writes are ignored and reads return 0.
- Not defined: addresses 4..7 ignore writes and read 0. No extra logic is present.

Test Plan:
- Reset: hold rst=0 with random bus activity -> leds=0 and readData=0. Release rst, read addresses 0..3 -> all return 0.
- Data write/readback: write DATA=0x1234_A5A5 -> leds=0xA5A5 after that edge. Read addr 0 -> readData=0x0000_A5A5 one cycle after readEnable, then 0 when readEnable drops.
- Blink: DATA=0x00FF, MASK=0x0F0F, PERIOD=3 -> leds alternate 0x00FF / 0x0FF0 every 4 cycles. Write PERIOD=0 -> leds hold 0x00FF and STATUS reads 0.
- Period rewrite mid-count: PERIOD=10, wait 7 cycles, write PERIOD=2 -> counter=0 and phase=0 on that edge; the next toggle occurs 3 cycles later.
- Same-address read+write: DATA=0x0001, then in one cycle write DATA=0x0002 with readEnable on addr 0 -> readData=0x0001, leds=0x0002. Write to addr 3 -> ignored.
- With LED_SETCLR_EN, DATA=0x00F0:
  - write addr4=0x000F -> leds=0x00FF
  - write addr5=0x0030 -> leds=0x00CF
  - write addr6=0xFFFF -> leds=0xFF30
  - Without the macro, the same writes leave leds=0x00F0.
- Reset mid-operation: assert rst=0 asynchronously mid-blink -> leds=0 before the next edge.
